// File: rtl/pipelined_adder_tree_acc_if.sv
// Beat-in / sum-out bundle for pipelined_adder_tree_acc; master drives lanes, slave is the tree.
interface pipelined_adder_tree_acc_if #(
   parameter int N_IN  = 32,
   parameter int IN_W  = 4,
   parameter int ACC_W = 16
);
   localparam int LVL   = $clog2(N_IN);
   localparam int SUM_W = IN_W + LVL;

   logic                   in_valid;
   logic [N_IN*IN_W-1:0]   in_data;
   logic                   in_first;
   logic                   in_last;
   logic                   tree_valid;
   logic [SUM_W-1:0]       tree_sum;
   logic                   acc_valid;
   logic [ACC_W-1:0]       acc_sum;
   logic                   acc_ovf;

   modport master (
      output in_valid, in_data, in_first, in_last,
      input  tree_valid, tree_sum, acc_valid, acc_sum, acc_ovf
   );

   modport slave (
      input  in_valid, in_data, in_first, in_last,
      output tree_valid, tree_sum, acc_valid, acc_sum, acc_ovf
   );
endinterface

// File: rtl/pipelined_adder_tree_acc.sv
// Pipelined N_IN-lane adder tree (registered input + one stage per level) with a burst accumulator.
// Define ADDER_TREE_ACC_SATURATE_EN to clamp the burst total on overflow instead of wrapping.
module pipelined_adder_tree_acc #(
   parameter int N_IN  = 32,
   parameter int IN_W  = 4,
   parameter int ACC_W = 16
) (
   input  logic clk,
   input  logic rst,
   pipelined_adder_tree_acc_if.slave bus
);
   localparam int LVL   = $clog2(N_IN);
   localparam int SUM_W = IN_W + LVL;

   typedef enum logic {IDLE, ACCUM} state_t;

   genvar gi;

   // Level 0 registers the raw lanes; level gi holds N_IN>>gi sums, each IN_W+gi bits wide.
   for (gi = 0; gi <= LVL; gi++) begin : g_lvl
      localparam int W = IN_W + gi;
      localparam int N = N_IN >> gi;

      logic [W-1:0] sum_reg [N];
      logic         vld_reg;
      logic         fst_reg;
      logic         lst_reg;

      if (gi == 0) begin : g_in
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < N; k++) sum_reg[k] <= '0;
               vld_reg <= 1'b0;
               fst_reg <= 1'b0;
               lst_reg <= 1'b0;
            end else begin
               for (int k = 0; k < N; k++) sum_reg[k] <= bus.in_data[IN_W*k +: IN_W];
               vld_reg <= bus.in_valid;
               fst_reg <= bus.in_valid & bus.in_first;
               lst_reg <= bus.in_valid & bus.in_last;
            end
         end
      end else begin : g_stage
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < N; k++) sum_reg[k] <= '0;
               vld_reg <= 1'b0;
               fst_reg <= 1'b0;
               lst_reg <= 1'b0;
            end else begin
               for (int k = 0; k < N; k++) begin
                  sum_reg[k] <= W'(g_lvl[gi-1].sum_reg[2*k]) + W'(g_lvl[gi-1].sum_reg[2*k+1]);
               end
               vld_reg <= g_lvl[gi-1].vld_reg;
               fst_reg <= g_lvl[gi-1].fst_reg;
               lst_reg <= g_lvl[gi-1].lst_reg;
            end
         end
      end
   end

   logic             tree_valid;
   logic [SUM_W-1:0] tree_sum;
   logic             tree_first;
   logic             tree_last;

   assign tree_valid = g_lvl[LVL].vld_reg;
   assign tree_sum   = g_lvl[LVL].sum_reg[0];
   assign tree_first = g_lvl[LVL].fst_reg;
   assign tree_last  = g_lvl[LVL].lst_reg;

   state_t           state_reg;
   logic             acc_valid_reg;
   logic [ACC_W-1:0] acc_sum_reg;
   logic             acc_ovf_reg;
   logic [ACC_W-1:0] tree_ext;
   logic [ACC_W:0]   add_full;

   // One extra bit on the adder exposes the carry out of the accumulator.
   assign tree_ext = ACC_W'(tree_sum);
   assign add_full = {1'b0, acc_sum_reg} + {1'b0, tree_ext};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         acc_valid_reg <= 1'b0;
         acc_sum_reg   <= '0;
         acc_ovf_reg   <= 1'b0;
      end else begin
         acc_valid_reg <= 1'b0;
         if (tree_valid) begin
            if (tree_first) begin
               acc_sum_reg   <= tree_ext;
               acc_ovf_reg   <= 1'b0;
               acc_valid_reg <= tree_last;
               state_reg     <= tree_last ? IDLE : ACCUM;
            end else if (state_reg == ACCUM) begin
`ifdef ADDER_TREE_ACC_SATURATE_EN
               if (acc_ovf_reg || add_full[ACC_W]) begin
                  acc_sum_reg <= '1;
               end else begin
                  acc_sum_reg <= add_full[ACC_W-1:0];
               end
`else
               acc_sum_reg <= add_full[ACC_W-1:0];
`endif
               acc_ovf_reg   <= acc_ovf_reg | add_full[ACC_W];
               acc_valid_reg <= tree_last;
               state_reg     <= tree_last ? IDLE : ACCUM;
            end
         end
      end
   end

   assign bus.tree_valid = tree_valid;
   assign bus.tree_sum   = tree_sum;
   assign bus.acc_valid  = acc_valid_reg;
   assign bus.acc_sum    = acc_sum_reg;
   assign bus.acc_ovf    = acc_ovf_reg;
endmodule

// File: tb/tb_pipelined_adder_tree_acc.sv
// Directed bench for pipelined_adder_tree_acc: 32x4 instance plus an 8x8 instance.
module tb_pipelined_adder_tree_acc;
   localparam int N_IN  = 32;
   localparam int IN_W  = 4;
   localparam int ACC_W = 16;
   localparam int DW    = N_IN * IN_W;
`ifdef ADDER_TREE_ACC_SATURATE_EN
   localparam int EXP_BIG = 65535;
`else
   localparam int EXP_BIG = 1664;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   int tree_cnt = 0;
   int acc_cnt = 0;
   logic [31:0] acc_cap = '0;
   logic ovf_cap = 1'b0;

   always #5 clk = ~clk;

   pipelined_adder_tree_acc_if #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(ACC_W)) bus ();
   pipelined_adder_tree_acc_if #(.N_IN(8), .IN_W(8), .ACC_W(16)) bus8 ();

   pipelined_adder_tree_acc #(.N_IN(N_IN), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   pipelined_adder_tree_acc #(.N_IN(8), .IN_W(8), .ACC_W(16)) dut8 (
      .clk(clk), .rst(rst), .bus(bus8)
   );

   always @(negedge clk) begin
      if (bus.tree_valid) tree_cnt = tree_cnt + 1;
      if (bus.acc_valid) begin
         acc_cnt = acc_cnt + 1;
         acc_cap = 32'(bus.acc_sum);
         ovf_cap = bus.acc_ovf;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic v, input logic f, input logic l, input logic [DW-1:0] d);
      bus.in_valid = v;
      bus.in_first = f;
      bus.in_last  = l;
      bus.in_data  = d;
   endtask

   initial begin
      logic [DW-1:0] d2;
      int base_t, base_a;

      set_beat(1'b0, 1'b0, 1'b0, '0);
      bus8.in_valid = 1'b0;
      bus8.in_first = 1'b0;
      bus8.in_last  = 1'b0;
      bus8.in_data  = '0;
      rst = 1'b1;
      tick();
      tick();
      check("rst_tree_valid", 32'(bus.tree_valid), 0);
      check("rst_tree_sum", 32'(bus.tree_sum), 0);
      check("rst_acc_valid", 32'(bus.acc_valid), 0);
      check("rst_acc_sum", 32'(bus.acc_sum), 0);
      check("rst_acc_ovf", 32'(bus.acc_ovf), 0);
      rst = 1'b0;
      tick();

      // 1: single-beat burst, all lanes 0xF
      set_beat(1'b1, 1'b1, 1'b1, '1);
      tick();
      set_beat(1'b0, 1'b0, 1'b0, '0);
      repeat (4) tick();
      check("t1_tree_not_early", 32'(bus.tree_valid), 0);
      tick();
      check("t1_tree_valid", 32'(bus.tree_valid), 1);
      check("t1_tree_sum", 32'(bus.tree_sum), 480);
      check("t1_acc_not_early", 32'(bus.acc_valid), 0);
      tick();
      check("t1_acc_valid", 32'(bus.acc_valid), 1);
      check("t1_acc_sum", 32'(bus.acc_sum), 480);
      check("t1_acc_ovf", 32'(bus.acc_ovf), 0);
      tick();
      check("t1_acc_pulse_end", 32'(bus.acc_valid), 0);
      check("t1_acc_hold", 32'(bus.acc_sum), 480);

      // 2: back-to-back beats, lane k = k mod 16, no first -> dropped by FSM
      for (int k = 0; k < N_IN; k++) d2[IN_W*k +: IN_W] = 4'(k % 16);
      base_t = tree_cnt;
      base_a = acc_cnt;
      for (int i = 0; i < 12; i++) begin
         set_beat(1'b1, 1'b0, 1'b0, d2);
         tick();
         if (i >= 5) begin
            check("t2_tree_valid", 32'(bus.tree_valid), 1);
            check("t2_tree_sum", 32'(bus.tree_sum), 240);
         end
      end
      set_beat(1'b0, 1'b0, 1'b0, '0);
      repeat (8) tick();
      check("t2_tree_count", 32'(tree_cnt - base_t), 12);
      check("t2_no_acc_pulse", 32'(acc_cnt - base_a), 0);

      // 3: burst 1,2,3,4 with two-cycle bubbles
      base_a = acc_cnt;
      for (int n = 1; n <= 4; n++) begin
         set_beat(1'b1, n == 1, n == 4, DW'(n));
         tick();
         set_beat(1'b0, 1'b0, 1'b0, '0);
         tick();
         tick();
      end
      repeat (8) tick();
      check("t3_pulses", 32'(acc_cnt - base_a), 1);
      check("t3_acc_sum", acc_cap, 10);
      check("t3_acc_ovf", 32'(ovf_cap), 0);
      check("t3_acc_hold", 32'(bus.acc_sum), 10);

      // 4: 140 beats of 480 -> overflow
      base_a = acc_cnt;
      for (int i = 0; i < 140; i++) begin
         set_beat(1'b1, i == 0, i == 139, '1);
         tick();
      end
      set_beat(1'b0, 1'b0, 1'b0, '0);
      repeat (8) tick();
      check("t4_pulses", 32'(acc_cnt - base_a), 1);
      check("t4_acc_sum", acc_cap, EXP_BIG);
      check("t4_acc_ovf", 32'(ovf_cap), 1);
      check("t4_ovf_hold", 32'(bus.acc_ovf), 1);

      // 5: restart mid-burst, then orphan beat while idle
      base_a = acc_cnt;
      set_beat(1'b1, 1'b1, 1'b0, DW'(5)); tick();
      set_beat(1'b1, 1'b0, 1'b0, DW'(6)); tick();
      set_beat(1'b1, 1'b1, 1'b0, DW'(7)); tick();
      set_beat(1'b1, 1'b0, 1'b1, DW'(8)); tick();
      set_beat(1'b0, 1'b0, 1'b0, '0);
      repeat (8) tick();
      check("t5_pulses", 32'(acc_cnt - base_a), 1);
      check("t5_acc_sum", acc_cap, 15);
      check("t5_ovf_cleared", 32'(ovf_cap), 0);
      set_beat(1'b1, 1'b0, 1'b1, DW'(9)); tick();
      set_beat(1'b0, 1'b0, 1'b0, '0);
      repeat (8) tick();
      check("t5_orphan_no_pulse", 32'(acc_cnt - base_a), 1);
      check("t5_orphan_acc_hold", 32'(bus.acc_sum), 15);

      // 6: async reset with three beats in flight
      base_t = tree_cnt;
      base_a = acc_cnt;
      set_beat(1'b1, 1'b1, 1'b0, DW'(3)); tick();
      set_beat(1'b1, 1'b0, 1'b0, DW'(3)); tick();
      set_beat(1'b1, 1'b0, 1'b1, DW'(3)); tick();
      set_beat(1'b0, 1'b0, 1'b0, '0);
      #2 rst = 1'b1;
      #1;
      check("t6_tree_valid", 32'(bus.tree_valid), 0);
      check("t6_tree_sum", 32'(bus.tree_sum), 0);
      check("t6_acc_valid", 32'(bus.acc_valid), 0);
      check("t6_acc_sum", 32'(bus.acc_sum), 0);
      check("t6_acc_ovf", 32'(bus.acc_ovf), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) tick();
      check("t6_no_tree_after_flush", 32'(tree_cnt - base_t), 0);
      check("t6_no_acc_after_flush", 32'(acc_cnt - base_a), 0);

      // 6b: 8x8 instance, all lanes 0xFF
      bus8.in_valid = 1'b1;
      bus8.in_first = 1'b1;
      bus8.in_last  = 1'b1;
      bus8.in_data  = '1;
      tick();
      bus8.in_valid = 1'b0;
      bus8.in_first = 1'b0;
      bus8.in_last  = 1'b0;
      bus8.in_data  = '0;
      repeat (2) tick();
      check("n8_tree_not_early", 32'(bus8.tree_valid), 0);
      tick();
      check("n8_tree_valid", 32'(bus8.tree_valid), 1);
      check("n8_tree_sum", 32'(bus8.tree_sum), 2040);
      tick();
      check("n8_acc_valid", 32'(bus8.acc_valid), 1);
      check("n8_acc_sum", 32'(bus8.acc_sum), 2040);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
